// File: rtl/oki_rom_pkg.sv
// Shared types for the dual-OKIM6295 sound-ROM arbiter: bank pages, chip
// addresses, arbiter states and the bank-page address splice.
package oki_rom_pkg;

   localparam int NUM_CHIPS = 2;

   typedef logic [4:0]  bank_t;
   typedef logic [17:0] oki_addr_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } arb_state_t;

   // The top two chip address bits pick a slot; that slot's page replaces them.
   function automatic logic [20:0] page_addr(input bank_t bank, input oki_addr_t addr);
      return {bank, addr[15:0]};
   endfunction

endpackage

// File: rtl/oki_rom_cache.sv
// One-entry read cache for a single OKI chip: holds the last fetched byte and
// reports a hit while the chip keeps presenting the same address.
module oki_rom_cache
   import oki_rom_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  oki_addr_t  rd_addr,
   input  logic       fill,
   input  oki_addr_t  fill_tag,
   input  logic [7:0] fill_data,
   input  logic       fill_keep,
   input  logic       inval,
   output logic [7:0] dout,
   output logic       valid
);

   oki_addr_t  tag;
   logic [7:0] data;
   logic       vld;

   // An invalidate on the same edge as a fill must win, so the entry is
   // written but left unusable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag  <= '0;
         data <= '0;
         vld  <= 1'b0;
      end else begin
         if (fill) begin
            tag  <= fill_tag;
            data <= fill_data;
         end
         if (inval) begin
            vld <= 1'b0;
         end else if (fill) begin
            vld <= fill_keep;
         end
      end
   end

   assign valid = vld && (tag == rd_addr);
   assign dout  = data;

endmodule

// File: rtl/oki_rom_arbiter.sv
// Shares one sound-ROM read port between two OKIM6295 chips, with NMK112-style
// per-chip bank switching and a one-entry read cache per chip.
module oki_rom_arbiter
   import oki_rom_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 24,
   parameter logic [ADDR_WIDTH-1:0] CHIP0_OFFSET = '0,
   parameter logic [ADDR_WIDTH-1:0] CHIP1_OFFSET = ADDR_WIDTH'(24'h200000)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [17:0]           oki0_rom_addr,
   output logic [7:0]            oki0_rom_dout,
   output logic                  oki0_rom_valid,
   input  logic [17:0]           oki1_rom_addr,
   output logic [7:0]            oki1_rom_dout,
   output logic                  oki1_rom_valid,
   input  logic                  bank_wr,
   input  logic [2:0]            bank_sel,
   input  logic [4:0]            bank_data,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_waitreq,
   input  logic                  mem_valid,
   input  logic [7:0]            mem_dout
);

   arb_state_t            state;
   arb_state_t            state_next;
   bank_t                 bank [NUM_CHIPS][4];
   oki_addr_t             chip_addr [NUM_CHIPS];
   logic [ADDR_WIDTH-1:0] chip_offset [NUM_CHIPS];
   logic [ADDR_WIDTH-1:0] phys [NUM_CHIPS];
   logic [7:0]            cache_dout [NUM_CHIPS];
   logic [NUM_CHIPS-1:0]  cache_hit;
   logic [NUM_CHIPS-1:0]  in_flight;
   logic [NUM_CHIPS-1:0]  miss;
   logic [NUM_CHIPS-1:0]  fill_en;
   logic [NUM_CHIPS-1:0]  inval_en;
   oki_addr_t             tag_req;
   logic                  gnt_chip;
   logic                  rr_chip;
   logic                  drop;
   logic                  grant;
   logic                  grant_chip;
   logic                  accept;
   logic                  fill_fire;

   assign chip_addr[0]   = oki0_rom_addr;
   assign chip_addr[1]   = oki1_rom_addr;
   assign chip_offset[0] = CHIP0_OFFSET;
   assign chip_offset[1] = CHIP1_OFFSET;

   // Physical byte address each chip would fetch right now.
   always_comb begin
      for (int n = 0; n < NUM_CHIPS; n++) begin
         phys[n] = chip_offset[n]
                 + ADDR_WIDTH'(page_addr(bank[n][chip_addr[n][17:16]], chip_addr[n]));
      end
   end

   always_comb begin
      for (int n = 0; n < NUM_CHIPS; n++) begin
         in_flight[n] = (state != IDLE) && (gnt_chip == 1'(n));
         miss[n]      = !cache_hit[n] && !in_flight[n];
         fill_en[n]   = fill_fire && (gnt_chip == 1'(n));
         inval_en[n]  = bank_wr && (bank_sel[2] == 1'(n));
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // rr_chip names the chip that wins the next contested grant.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_chip = rr_chip;
      accept     = 1'b0;
      fill_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (|miss) begin
               grant      = 1'b1;
               grant_chip = (&miss) ? rr_chip : miss[1];
               state_next = REQ;
            end
         end
         REQ: begin
            if (!mem_waitreq) begin
               accept     = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (mem_valid) begin
               fill_fire  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A bank write to the chip being fetched (or granted on this very edge)
   // poisons the fetch, since its address came from the old mapping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gnt_chip <= 1'b0;
         rr_chip  <= 1'b0;
         tag_req  <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         drop     <= 1'b0;
      end else begin
         if (grant) begin
            gnt_chip <= grant_chip;
            tag_req  <= chip_addr[grant_chip];
            mem_addr <= phys[grant_chip];
            mem_rd   <= 1'b1;
            if (&miss) begin
               rr_chip <= ~grant_chip;
            end
         end
         if (accept) begin
            mem_rd <= 1'b0;
         end
         if (fill_fire) begin
            drop <= 1'b0;
         end else if (bank_wr &&
                      ((grant && (bank_sel[2] == grant_chip)) ||
                       ((state != IDLE) && (bank_sel[2] == gnt_chip)))) begin
            drop <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CHIPS; c++) begin
            for (int s = 0; s < 4; s++) begin
               bank[c][s] <= bank_t'(s);
            end
         end
      end else if (bank_wr) begin
         bank[bank_sel[2]][bank_sel[1:0]] <= bank_data;
      end
   end

   for (genvar n = 0; n < NUM_CHIPS; n++) begin : g_cache
      oki_rom_cache u_cache (
         .clock     (clock),
         .reset_n   (reset_n),
         .rd_addr   (chip_addr[n]),
         .fill      (fill_en[n]),
         .fill_tag  (tag_req),
         .fill_data (mem_dout),
         .fill_keep (!drop),
         .inval     (inval_en[n]),
         .dout      (cache_dout[n]),
         .valid     (cache_hit[n])
      );
   end

   assign oki0_rom_dout  = cache_dout[0];
   assign oki0_rom_valid = cache_hit[0];
   assign oki1_rom_dout  = cache_dout[1];
   assign oki1_rom_valid = cache_hit[1];

endmodule
